// File: rtl/mem_write_a_ctrl.sv
// mem_write_a_ctrl: write-address and one-hot bank-select generator for the matrix-A operand banks.
// Two fill orders are supported: bank-sequential (blk->bank->col) and bank-interleaved (blk->col->bank).
module mem_write_a_ctrl #(
    parameter int N1           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W       = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MATRIXSIZE_W-1:0] M2,
    input  logic [MATRIXSIZE_W-1:0] M1dN1,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    wr_en_A,
    output logic [ADDR_W-1:0]       wr_addr_A,
    output logic [N1-1:0]           activate_A,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);
    localparam int BW = N1 > 1 ? $clog2(N1) : 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [MATRIXSIZE_W-1:0] m2_q, m2_d, m1_q, m1_d;
    logic                    mode_q, mode_d;
    logic [MATRIXSIZE_W-1:0] blk_q, blk_d, col_q, col_d;
    logic [BW-1:0]           bank_q, bank_d;
    logic [ADDR_W-1:0]       base_q, base_d, addr_q, addr_d;
    logic [N1-1:0]           act_q, act_d;
    logic                    done_q, done_d, err_q, err_d;
    logic                    last_col, last_bank, last_blk, adv_blk;

    assign in_ready   = state_q == WRITE;
    assign busy       = state_q == WRITE;
    assign wr_en_A    = in_valid & in_ready;
    assign wr_addr_A  = addr_q;
    assign activate_A = act_q;
    assign done       = done_q;
    assign cfg_err    = err_q;

    // Wrap tests use the latched sizes so mid-fill input changes cannot disturb the sequence.
    assign last_col  = col_q == m2_q - 1'b1;
    assign last_bank = bank_q == BW'(N1 - 1);
    assign last_blk  = blk_q == m1_q - 1'b1;
    assign adv_blk   = last_col & last_bank;

    always_comb begin
        state_d = state_q;
        m2_d    = m2_q;
        m1_d    = m1_q;
        mode_d  = mode_q;
        blk_d   = blk_q;
        col_d   = col_q;
        bank_d  = bank_q;
        base_d  = base_q;
        addr_d  = addr_q;
        act_d   = act_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                m2_d   = M2;
                m1_d   = M1dN1;
                mode_d = mode;
                if (M2 == '0 || M1dN1 == '0) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    state_d = WRITE;
                    blk_d   = '0;
                    col_d   = '0;
                    bank_d  = '0;
                    base_d  = '0;
                    addr_d  = '0;
                    act_d   = N1'(1);
                end
            end
        end else if (wr_en_A) begin
            if (!mode_q) begin
                col_d  = last_col ? '0 : col_q + 1'b1;
                bank_d = last_col ? (last_bank ? '0 : bank_q + 1'b1) : bank_q;
            end else begin
                bank_d = last_bank ? '0 : bank_q + 1'b1;
                col_d  = last_bank ? (last_col ? '0 : col_q + 1'b1) : col_q;
            end
            blk_d  = adv_blk ? blk_q + 1'b1 : blk_q;
            base_d = adv_blk ? base_q + ADDR_W'(m2_q) : base_q;
            if (adv_blk && last_blk) begin
                state_d = IDLE;
                done_d  = 1'b1;
                addr_d  = '0;
                act_d   = '0;
            end else begin
                addr_d = base_d + ADDR_W'(col_d);
                act_d  = N1'(1) << bank_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m2_q    <= '0;
            m1_q    <= '0;
            mode_q  <= 1'b0;
            blk_q   <= '0;
            col_q   <= '0;
            bank_q  <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            act_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m2_q    <= m2_d;
            m1_q    <= m1_d;
            mode_q  <= mode_d;
            blk_q   <= blk_d;
            col_q   <= col_d;
            bank_q  <= bank_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            act_q   <= act_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_write_a_ctrl.sv
// tb_mem_write_a_ctrl: scoreboard bench; expected (addr, bank) slots are queued when a fill is launched
// and popped as the DUT strobes wr_en_A.
module tb_mem_write_a_ctrl;
    logic        clk, rst, start, mode, in_valid;
    logic [15:0] M2, M1dN1;
    logic        in_ready, wr_en_A, busy, done, cfg_err;
    logic [11:0] wr_addr_A;
    logic [3:0]  activate_A;

    typedef struct packed {
        logic [11:0] a;
        logic [3:0]  act;
    } slot_t;

    slot_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    wr_cnt  = 0;

    mem_write_a_ctrl #(.N1(4), .MATRIXSIZE_W(16), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .M2(M2), .M1dN1(M1dN1), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en_A(wr_en_A), .wr_addr_A(wr_addr_A),
        .activate_A(activate_A), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int m2, input int m1, input bit md);
        slot_t s;
        for (int b = 0; b < m1; b++) begin
            if (!md) begin
                for (int k = 0; k < 4; k++)
                    for (int c = 0; c < m2; c++) begin
                        s.a = 12'(b * m2 + c); s.act = 4'(1 << k); q.push_back(s);
                    end
            end else begin
                for (int c = 0; c < m2; c++)
                    for (int k = 0; k < 4; k++) begin
                        s.a = 12'(b * m2 + c); s.act = 4'(1 << k); q.push_back(s);
                    end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && busy) begin
            check("wr_en", wr_en_A, in_valid);
            if (wr_en_A) begin
                wr_cnt++;
                if (q.size() == 0) check("extra_wr", 1, 0);
                else begin
                    slot_t s;
                    s = q.pop_front();
                    check("addr", wr_addr_A, s.a);
                    check("act", activate_A, s.act);
                end
            end
        end else if (!rst) begin
            check("idle_outs", {wr_en_A, in_ready, activate_A, wr_addr_A}, 0);
        end
    end

    task automatic fill(input int m2, input int m1, input bit md, input bit rnd, input bit disturb);
        int cyc;
        int exp_n;
        exp_n  = m2 * 4 * m1;
        push_exp(m2, m1, md);
        wr_cnt = 0;
        start = 1'b1; M2 = 16'(m2); M1dN1 = 16'(m1); mode = md; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start", busy, 1);
        check("rdy_start", in_ready, 1);
        cyc = 0;
        while (!done && cyc < 1000) begin
            in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (disturb) begin
                start = (cyc == 5);
                M2    = 16'd7;
                mode  = ~md;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0;
        check("done", done, 1);
        check("cfg_err_ok", cfg_err, 0);
        check("busy_end", busy, 0);
        check("rdy_end", in_ready, 0);
        check("nwr", wr_cnt, exp_n);
        check("q_empty", q.size(), 0);
        if (!rnd) check("latency", cyc, exp_n);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; M2 = '0; M1dN1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", {in_ready, wr_en_A, wr_addr_A, activate_A, busy, done, cfg_err}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        fill(3, 2, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("done_pulse", {done, cfg_err}, 0);
        fill(3, 2, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        fill(3, 2, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; M2 = 16'd0; M1dN1 = 16'd5; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("cfg_done", done, 1);
        check("cfg_err", cfg_err, 1);
        check("cfg_busy", busy, 0);
        @(posedge clk); #1;
        check("cfg_pulse", {done, cfg_err, busy}, 0);
        push_exp(3, 2, 1'b0);
        start = 1'b1; M2 = 16'd3; M1dN1 = 16'd2; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_outs", {in_ready, wr_en_A, wr_addr_A, activate_A, busy, done, cfg_err}, 0);
        rst = 1'b0;
        q.delete();
        @(posedge clk); #1;
        fill(3, 2, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        fill(3, 2, 1'b0, 1'b0, 1'b1);
        fill(2, 3, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_write_a_ctrl.md
# mem_write_a_ctrl

Parametrised write-address generator for the matrix-A operand banks of the ece327 matrix-multiply datapath. It accepts a stream of A elements under a valid/ready handshake and steers each element to one of N1 one-hot-selected banks at a generated address. It supports two runtime-selectable fill orders, latches its configuration at start, and reports completion and configuration errors. It sits between the input streamer and the N1 A-bank write ports.

## Interface
- N1, 4: number of A banks (one-hot width of activate_A), ≥1
- MATRIXSIZE_W, 16: width of the matrix dimension inputs
- ADDR_W, 12: bank address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a fill; sampled only in IDLE
- M2  in  MATRIXSIZE_W  row length (columns per bank row block); latched on start
- M1dN1  in  MATRIXSIZE_W  row blocks per bank (M1/N1); latched on start
- mode  in  1  0 = bank-sequential, 1 = bank-interleaved; latched on start
- in_valid  in  1  element present on the upstream stream
- in_ready  out  1  block can accept an element this cycle
- wr_en_A  out  1  write strobe to the selected bank
- wr_addr_A  out  ADDR_W  write address for the current slot
- activate_A  out  N1  one-hot bank select for the current slot
- busy  out  1  fill in progress
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  set with done when the latched M2 or M1dN1 is zero

## Operation
- States: IDLE, WRITE.
- IDLE: in_ready=0, activate_A=0, wr_addr_A=0. On start=1, latch M2/M1dN1/mode.
  - Both latched sizes nonzero: go to WRITE with blk=0, col=0, bank=0, base=0.
  - Either size zero: stay in IDLE and pulse done and cfg_err next cycle. No writes.
- WRITE: in_ready=1. wr_addr_A=base+col and activate_A=1<<bank, both registered.
  - wr_en_A = in_valid & in_ready (combinational).
  - The slot advances only on an accepted beat (wr_en_A=1). in_valid=0 holds the slot; no slot is ever skipped.
- Mode 0 (bank-sequential), nesting order blk→bank→col:
  - col increments to M2-1.
  - At the col wrap, bank increments and col returns to 0.
  - At the bank wrap, base += M2 and blk increments.
- Mode 1 (bank-interleaved), nesting order blk→col→bank:
  - bank increments every beat.
  - At the bank wrap, col increments.
  - At the col wrap, base += M2 and blk increments.
- Total beats per fill: M2·N1·M1dN1. Each bank receives addresses 0 to M2·M1dN1−1 exactly once.
- Final beat (blk=M1dN1−1, last col, last bank) accepted: go to IDLE, with done=1 and cfg_err=0 the next cycle.
- Arithmetic:
  - base and address are ADDR_W bits and wrap modulo 2^ADDR_W.
  - Sizing M2·M1dN1 ≤ 2^ADDR_W is the integrator's responsibility; there is no overflow detection.
  - Counters compare against the latched values, never the live inputs.
- start while in WRITE is ignored. Changes on M2/M1dN1/mode mid-fill have no effect.
- busy = (state==WRITE).

## Timing
- Reset values: in_ready=0, wr_en_A=0, wr_addr_A=0, activate_A=0, busy=0, done=0, cfg_err=0, state=IDLE. Reset applies mid-fill too: the fill is abandoned and the next cycle is IDLE with no done pulse.
- start at cycle T (in IDLE) gives busy=1, in_ready=1, slot 0 presented at T+1.
- Throughput: one element per cycle with in_valid held high. Latency from start to the last write is M2·N1·M1dN1 cycles.
- Last beat accepted at cycle L gives done=1, busy=0, in_ready=0 at L+1.
- A start at L+1 is accepted; its first slot appears at L+2.
- done and cfg_err are high for exactly one cycle.

## Test plan
- N1=4, M2=3, M1dN1=2, mode 0, in_valid=1 throughout:
  - 24 writes.
  - (addr, activate) sequence: 0,1,2 @0001; 0,1,2 @0010; 0,1,2 @0100; 0,1,2 @1000; then 3,4,5 repeating over each bank.
  - done one cycle after the 24th beat.
- Same sizes, mode 1: sequence (0,0001),(0,0010),(0,0100),(0,1000),(1,0001)…(5,1000). 24 writes, then done.
- Mode 0 with in_valid toggling pseudo-randomly: the accepted sequence is identical to the first case. wr_en_A=0 whenever in_valid=0, and the slot is held.
- start with M2=0, M1dN1=5: no wr_en_A ever; done=1 and cfg_err=1 at T+1; busy stays 0.
- rst asserted after beat 10 of the first case: the next cycle has all outputs at reset values and no done. A new start then restarts from addr 0 @0001.
- start pulsed and M2 changed to 7 mid-fill: ignored, the fill completes as originally configured. start in the done cycle launches a second fill at L+2.
